// File: rtl/cacheline_adaptor_if.sv
// Cache-side and physical-memory-side signal bundle for cacheline_adaptor.
// master = arbiter/memory environment, slave = the adaptor itself.
interface cacheline_adaptor_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cache_read;
  logic              cache_write;
  logic [ADDR_W-1:0] cache_addr;
  logic [255:0]      cache_wdata;
  logic [255:0]      cache_rdata;
  logic              cache_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [63:0]       pmem_wdata;
  logic [63:0]       pmem_rdata;
  logic              pmem_resp;

  modport master (
    output cache_read, cache_write, cache_addr, cache_wdata, pmem_rdata, pmem_resp,
    input  cache_rdata, cache_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport slave (
    input  cache_read, cache_write, cache_addr, cache_wdata, pmem_rdata, pmem_resp,
    output cache_rdata, cache_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit line reads/writes into 4-beat 64-bit memory bursts.
// Define CACHELINE_ADAPTOR_STATS_EN to add rd_bursts/wr_bursts completion counters.
module cacheline_adaptor #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  cacheline_adaptor_if.slave bus
`ifdef CACHELINE_ADAPTOR_STATS_EN
  ,
  output logic [31:0] rd_bursts,
  output logic [31:0] wr_bursts
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q,   cnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [255:0]      wdata_q, wdata_d;
  logic [255:0]      rdata_q, rdata_d;
  logic [7:0]        beat_lsb;
  logic              last_beat;
  logic              addr_lo_unused;

  assign beat_lsb       = {cnt_q, 6'd0};
  assign last_beat      = bus.pmem_resp && (cnt_q == 2'd3);
  assign addr_lo_unused = ^bus.cache_addr[4:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cache_write) begin
          state_d = WR_BURST;
          addr_d  = {bus.cache_addr[ADDR_W-1:5], 5'b0};
          wdata_d = bus.cache_wdata;
          cnt_d   = '0;
        end else if (bus.cache_read) begin
          state_d = RD_BURST;
          addr_d  = {bus.cache_addr[ADDR_W-1:5], 5'b0};
          cnt_d   = '0;
        end
      end
      RD_BURST: begin
        if (bus.pmem_resp) begin
          rdata_d[beat_lsb +: 64] = bus.pmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (last_beat) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (bus.pmem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset clears them at once.
  assign bus.pmem_read   = (state_q == RD_BURST);
  assign bus.pmem_write  = (state_q == WR_BURST);
  assign bus.cache_resp  = (state_q == DONE);
  assign bus.pmem_addr   = addr_q;
  assign bus.pmem_wdata  = wdata_q[beat_lsb +: 64];
  assign bus.cache_rdata = rdata_q;

`ifdef CACHELINE_ADAPTOR_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (state_q == RD_BURST && last_beat) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (state_q == WR_BURST && last_beat) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_bursts = rd_cnt_q;
  assign wr_bursts = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: directed cases plus randomized line traffic.
module tb_cacheline_adaptor;

  typedef struct {
    bit           is_rd;
    logic [31:0]  addr;
    logic [255:0] line;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  txn_t         exp_q[$];
  logic [63:0]  exp_wbeats[$];
  logic [63:0]  mem_beats[$];
  logic [255:0] hold_line = '0;
  int unsigned  gaps[4] = '{0, 0, 0, 0};
  int unsigned  beats_done = 0;
  int unsigned  mdl_rd = 0;
  int unsigned  mdl_wr = 0;

  cacheline_adaptor_if #(.ADDR_W(32)) bus ();

`ifdef CACHELINE_ADAPTOR_STATS_EN
  logic [31:0] rd_bursts, wr_bursts;
  cacheline_adaptor #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .rd_bursts(rd_bursts), .wr_bursts(wr_bursts)
  );
`else
  cacheline_adaptor #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Memory model: answers each burst with per-beat gaps taken from gaps[].
  initial begin : responder
    bit was_active;
    int unsigned bidx, gap_left;
    was_active = 1'b0;
    bidx = 0;
    gap_left = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
        if (!was_active) begin
          bidx = 0;
          gap_left = gaps[0];
        end
        was_active = 1'b1;
        if (gap_left > 0) begin
          gap_left--;
          bus.pmem_resp = 1'b0;
        end else begin
          bus.pmem_resp = 1'b1;
          if (bus.pmem_read && mem_beats.size() > 0) bus.pmem_rdata = mem_beats.pop_front();
          else bus.pmem_rdata = {$urandom, $urandom};
          bidx++;
          beats_done++;
          gap_left = (bidx < 4) ? gaps[bidx] : 0;
        end
      end else begin
        was_active = 1'b0;
        bus.pmem_resp = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every write beat and every completion.
  initial begin : monitor
    txn_t t;
    logic [63:0] wb;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.pmem_resp && bus.pmem_write) begin
          if (exp_wbeats.size() == 0) check("spurious_wbeat", 1'b1, 1'b0);
          else begin
            wb = exp_wbeats.pop_front();
            check("wbeat", bus.pmem_wdata, wb);
          end
        end
        if (bus.cache_resp) begin
          if (exp_q.size() == 0) check("spurious_cache_resp", 1'b1, 1'b0);
          else begin
            t = exp_q.pop_front();
            check("pmem_addr", bus.pmem_addr, t.addr);
            check(t.is_rd ? "rd_line" : "rdata_hold", bus.cache_rdata, t.line);
            if (t.is_rd) mdl_rd++;
            else mdl_wr++;
          end
        end
      end
    end
  end

  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wdata, input logic [255:0] rline,
                        input int unsigned g0, input int unsigned g1,
                        input int unsigned g2, input int unsigned g3);
    txn_t t;
    int unsigned lat, bad, exp_lat;
    t.is_rd = !wr;
    t.addr  = {addr[31:5], 5'b0};
    t.line  = wr ? hold_line : rline;
    if (!wr) hold_line = rline;
    gaps = '{g0, g1, g2, g3};
    exp_lat = 5 + g0 + g1 + g2 + g3;
    for (int k = 0; k < 4; k++) begin
      if (wr) exp_wbeats.push_back(wdata[k*64 +: 64]);
      else    mem_beats.push_back(rline[k*64 +: 64]);
    end
    exp_q.push_back(t);
    @(posedge clk); #1;
    bus.cache_read  = rd;
    bus.cache_write = wr;
    bus.cache_addr  = addr;
    bus.cache_wdata = wdata;
    lat = 0;
    bad = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (bus.cache_resp) break;
      if (wr ? !(bus.pmem_write && !bus.pmem_read) : !(bus.pmem_read && !bus.pmem_write)) bad++;
    end
    if (!bus.cache_resp) check("resp_timeout", bus.cache_resp, 1'b1);
    bus.cache_read  = 1'b0;
    bus.cache_write = 1'b0;
    check("latency", lat, exp_lat);
    check("strobe_held", bad, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cache_resp"},  bus.cache_resp, 1'b0);
    check({tag, "_pmem_read"},   bus.pmem_read, 1'b0);
    check({tag, "_pmem_write"},  bus.pmem_write, 1'b0);
    check({tag, "_pmem_addr"},   bus.pmem_addr, 32'h0);
    check({tag, "_pmem_wdata"},  bus.pmem_wdata, 64'h0);
    check({tag, "_cache_rdata"}, bus.cache_rdata, 256'h0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.cache_read  = 1'b0;
    bus.cache_write = 1'b0;
    mem_beats.delete();
    exp_wbeats.delete();
    hold_line = '0;
    mdl_rd = 0;
    mdl_wr = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stimulus
    int unsigned w;
    rst_n = 1'b0;
    bus.cache_read  = 1'b0;
    bus.cache_write = 1'b0;
    bus.cache_addr  = '0;
    bus.cache_wdata = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    #1 rst_n = 1'b1;

    // Directed read: fixed beats, back-to-back responses.
    do_txn(1'b1, 1'b0, 32'h0000_1234, '0,
           {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0, 0, 0);
    // Directed write: beats A, B, C, D in order.
    do_txn(1'b0, 1'b1, 32'h0000_8040,
           {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, '0, 0, 0, 0, 0);
    // Stall: two idle cycles before the third beat.
    do_txn(1'b1, 1'b0, 32'hABCD_EF1F, '0, rand_line(), 0, 0, 2, 0);
    // Simultaneous request: write must win.
    do_txn(1'b1, 1'b1, 32'h0000_0FE0, rand_line(), rand_line(), 0, 1, 0, 0);

    // Reset in the middle of a read burst.
    gaps = '{0, 0, 0, 0};
    for (int k = 0; k < 4; k++) mem_beats.push_back({$urandom, $urandom});
    beats_done = 0;
    @(posedge clk); #1;
    bus.cache_read = 1'b1;
    bus.cache_addr = 32'h1357_9BDF;
    w = 0;
    while (beats_done < 2 && w < 50) begin
      @(posedge clk); #2;
      w++;
    end
    check("rst_mid_beats", beats_done, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.cache_read = 1'b0;
    #1 check_all_zero("rst_mid");
    mem_beats.delete();
    hold_line = '0;
    mdl_rd = 0;
    mdl_wr = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    do_txn(1'b1, 1'b0, 32'h2468_ACE0, '0, rand_line(), 0, 0, 0, 0);

    // Randomized mix of reads, writes and both, with random beat gaps.
    for (int n = 0; n < 24; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_txn(kind != 1, kind != 0, $urandom, rand_line(), rand_line(),
             $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Fresh reset, then 3 reads and 2 writes.
    apply_reset();
    for (int n = 0; n < 3; n++)
      do_txn(1'b1, 1'b0, $urandom, '0, rand_line(), 0, $urandom_range(0, 1), 0, 0);
    for (int n = 0; n < 2; n++)
      do_txn(1'b0, 1'b1, $urandom, rand_line(), '0, 0, 0, $urandom_range(0, 1), 0);
    repeat (3) @(posedge clk);
    check("model_rd_count", mdl_rd, 3);
    check("model_wr_count", mdl_wr, 2);
`ifdef CACHELINE_ADAPTOR_STATS_EN
    check("rd_bursts", rd_bursts, 32'd3);
    check("wr_bursts", wr_bursts, 32'd2);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rd_bursts_rst", rd_bursts, 32'd0);
    check("wr_bursts_rst", wr_bursts, 32'd0);
    #2 rst_n = 1'b1;
`endif
    check("exp_q_empty", exp_q.size(), 0);
    check("exp_wbeats_empty", exp_wbeats.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter: ADDR_W, 32, line and burst address width.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: cache_read  in  1  line read request from the arbiter, held until cache_resp.
REQ-005 Port: cache_write  in  1  line write request from the arbiter, held until cache_resp.
REQ-006 Port: cache_addr  in  ADDR_W  line address; bits [4:0] ignored.
REQ-007 Port: cache_wdata  in  256  write line; bits [64k+63:64k] are beat k.
REQ-008 Port: cache_rdata  out  256  assembled read line.
REQ-009 Port: cache_resp  out  1  one-cycle completion pulse to the arbiter.
REQ-010 Port: pmem_read  out  1  burst read request to physical memory.
REQ-011 Port: pmem_write  out  1  burst write request to physical memory.
REQ-012 Port: pmem_addr  out  ADDR_W  burst base address, 32-byte aligned.
REQ-013 Port: pmem_wdata  out  64  current write beat.
REQ-014 Port: pmem_rdata  in  64  read beat, valid when pmem_resp=1.
REQ-015 Port: pmem_resp  in  1  per-beat acknowledge from memory; 4 per burst.

Function
REQ-016 The FSM SHALL have states IDLE, RD_BURST, WR_BURST, DONE.
REQ-017 IDLE SHALL go to WR_BURST when cache_write=1, otherwise to RD_BURST when cache_read=1, otherwise stay; write wins if both are high.
REQ-018 On leaving IDLE, the block SHALL register {cache_addr[ADDR_W-1:5],5'b0} into pmem_addr, register cache_wdata for writes, and clear the 2-bit beat counter.
REQ-019 In RD_BURST, pmem_read SHALL be 1; each cycle with pmem_resp=1 SHALL store pmem_rdata into cache_rdata beat[counter] and increment the counter.
REQ-020 In WR_BURST, pmem_write SHALL be 1 and pmem_wdata SHALL equal registered beat[counter]; each pmem_resp=1 SHALL increment the counter.
REQ-021 When pmem_resp=1 with counter=3, the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-022 In DONE, cache_resp SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-023 cache_resp, pmem_read, and pmem_write SHALL be 0 in every state not named above.
REQ-024 cache_rdata SHALL hold its value from DONE until the next read burst writes beat 0; write bursts SHALL NOT modify it.
REQ-025 Minimum latency with back-to-back pmem_resp SHALL be: request in cycle 0, pmem_read/pmem_write in cycles 1-4, cache_resp in cycle 5.
REQ-026 Gaps in pmem_resp SHALL stall the burst with all outputs held; there is no timeout.
REQ-027 Request changes during RD_BURST, WR_BURST, or DONE SHALL be ignored.
REQ-028 The requester drops its request in the cycle after cache_resp; a request still high in IDLE SHALL start a new burst.

Reset
REQ-029 rst_n=0 SHALL immediately force state to IDLE, counter to 0, and set cache_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata, and cache_rdata to 0.
REQ-030 Reset mid-burst SHALL abort the burst with no cache_resp; the first edge after release SHALL evaluate IDLE rules.

Configuration
REQ-031 With CACHELINE_ADAPTOR_STATS_EN defined, the block SHALL add outputs rd_bursts (out, 32) and wr_bursts (out, 32).
REQ-032 These counters SHALL be reset to 0 and SHALL increment, wrapping, on entering DONE from RD_BURST or WR_BURST respectively.
REQ-033 Without CACHELINE_ADAPTOR_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Read case: cache_read with cache_addr=0x0000_1234, pmem_rdata beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with back-to-back pmem_resp. Required response: pmem_addr=0x0000_1220; cache_rdata={0x44..44,0x33..33,0x22..22,0x11..11}; cache_resp in cycle 5.
REQ-035 Write case: cache_write with cache_wdata={4 beats 0xD..,0xC..,0xB..,0xA..}. Required response: pmem_wdata=0xA..,0xB..,0xC..,0xD.. on successive pmem_resp; a single-cycle cache_resp.
REQ-036 Stall case: read with 2 idle cycles between beats 1 and 2. Required response: pmem_read held high; cache_resp in cycle 7; data correct.
REQ-037 Simultaneous request: cache_read=cache_write=1 in IDLE. Required response: WR_BURST taken; pmem_read never asserted.
REQ-038 Reset mid-burst: rst_n=0 after beat 2 of a read. Required response: all outputs 0 immediately, no cache_resp; the next read completes normally.
REQ-039 Stats case, with CACHELINE_ADAPTOR_STATS_EN: 3 reads then 2 writes. Required response: rd_bursts=3, wr_bursts=2; reset returns both to 0.
